// File: rtl/phys_reg_free_table_pkg.sv
// Shared rename definitions: default table geometry and the index/count types
// used by the physical-register free table and its clients.
package phys_reg_free_table_pkg;

  localparam int DEF_ENTRY_COUNT = 64;
  localparam int DEF_RESERVED    = 32;
  localparam int DEF_IDX_W       = $clog2(DEF_ENTRY_COUNT);
  localparam int DEF_CNT_W       = $clog2(DEF_ENTRY_COUNT + 1);

  typedef logic [DEF_IDX_W-1:0] phys_idx_t;
  typedef logic [DEF_CNT_W-1:0] free_cnt_t;

endpackage

// File: rtl/phys_reg_free_table_priority_encoder.sv
// Lowest-zero priority encoder: a 0 bit in free_table marks a free entry,
// which matches the busy-map convention so the map is fed in directly.
module priority_encoder #(
  parameter  int WIDTH = 64,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] free_table,
  output logic             found,
  output logic [IDX_W-1:0] index
);

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    found = 1'b0;
    index = '0;
    // Scan from the top so the last hit written is the lowest free entry.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!free_table[i]) begin
        found = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/phys_reg_free_table.sv
// Physical-register busy bitmap for rename: lowest-free allocation, two
// indexed release ports, whole-table flush recovery and a running free count.
module phys_reg_free_table
  import phys_reg_free_table_pkg::*;
#(
  parameter  int ENTRY_COUNT = DEF_ENTRY_COUNT,
  parameter  int RESERVED    = DEF_RESERVED,
  localparam int IDX_W       = $clog2(ENTRY_COUNT),
  localparam int CNT_W       = $clog2(ENTRY_COUNT + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_req,
  output logic                   alloc_ready,
  output logic [IDX_W-1:0]       alloc_index,
  input  logic [1:0]             rel_valid,
  input  logic [IDX_W-1:0]       rel_index0,
  input  logic [IDX_W-1:0]       rel_index1,
  input  logic                   recover_valid,
  input  logic [ENTRY_COUNT-1:0] recover_busy,
  output logic [ENTRY_COUNT-1:0] busy_table,
  output logic [CNT_W-1:0]       free_count,
  output logic                   double_free
);

  // Low RESERVED entries hold the initial architectural mappings.
  localparam logic [ENTRY_COUNT-1:0] RESET_MAP =
    (ENTRY_COUNT'(1) << RESERVED) - ENTRY_COUNT'(1);

  function automatic logic [CNT_W-1:0] count_free(input logic [ENTRY_COUNT-1:0] map);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < ENTRY_COUNT; i++) n += CNT_W'(!map[i]);
    return n;
  endfunction

  logic                   alloc_fire;
  logic                   hit0;
  logic                   hit1;
  logic                   bad_release;
  logic [ENTRY_COUNT-1:0] busy_next;
  logic [CNT_W-1:0]       free_next;

  priority_encoder #(.WIDTH(ENTRY_COUNT)) u_lowest_free (
    .free_table (busy_table),
    .found      (alloc_ready),
    .index      (alloc_index)
  );

  always_comb begin
    alloc_fire = alloc_req & alloc_ready;
    hit0       = rel_valid[0] & busy_table[rel_index0];
    // Port 1 naming the entry port 0 already freed is a duplicate, not a second free.
    hit1       = rel_valid[1] & busy_table[rel_index1] & ~(hit0 & (rel_index0 == rel_index1));
    bad_release = (rel_valid[0] & ~hit0) | (rel_valid[1] & ~hit1);

    busy_next = busy_table;
    // The allocated bit is free and released bits are busy, so set and clear never collide.
    if (alloc_fire) busy_next[alloc_index] = 1'b1;
    if (hit0)       busy_next[rel_index0]  = 1'b0;
    if (hit1)       busy_next[rel_index1]  = 1'b0;

    free_next = free_count - CNT_W'(alloc_fire) + CNT_W'(hit0) + CNT_W'(hit1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_table  <= RESET_MAP;
      free_count  <= CNT_W'(ENTRY_COUNT - RESERVED);
      double_free <= 1'b0;
    end else if (recover_valid) begin
      busy_table <= recover_busy;
      free_count <= count_free(recover_busy);
    end else begin
      busy_table  <= busy_next;
      free_count  <= free_next;
      double_free <= double_free | bad_release;
    end
  end

endmodule

// File: tb/tb_phys_reg_free_table.sv
// Self-checking bench for phys_reg_free_table: directed vector table, a fill /
// drain sequence, then randomized traffic against a bitmap reference model.
module tb_phys_reg_free_table;
  import phys_reg_free_table_pkg::*;

  localparam int N = 64;
  localparam logic [N-1:0] RESET_MAP = 64'h00000000_FFFFFFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alloc_req = 1'b0;
  logic        alloc_ready;
  phys_idx_t   alloc_index;
  logic [1:0]  rel_valid = 2'b00;
  phys_idx_t   rel_index0 = '0;
  phys_idx_t   rel_index1 = '0;
  logic        recover_valid = 1'b0;
  logic [N-1:0] recover_busy = '0;
  logic [N-1:0] busy_table;
  free_cnt_t   free_count;
  logic        double_free;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  phys_reg_free_table dut (
    .clk           (clk),
    .rst           (rst),
    .alloc_req     (alloc_req),
    .alloc_ready   (alloc_ready),
    .alloc_index   (alloc_index),
    .rel_valid     (rel_valid),
    .rel_index0    (rel_index0),
    .rel_index1    (rel_index1),
    .recover_valid (recover_valid),
    .recover_busy  (recover_busy),
    .busy_table    (busy_table),
    .free_count    (free_count),
    .double_free   (double_free)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; alloc_req = 1'b0; rel_valid = 2'b00;
    rel_index0 = '0; rel_index1 = '0; recover_valid = 1'b0; recover_busy = '0;
  endtask

  typedef struct {
    logic        rst;
    logic        alloc;
    logic [1:0]  rv;
    int          r0;
    int          r1;
    logic        rec;
    logic [63:0] rec_busy;
    logic [63:0] exp_busy;
    int          exp_free;
    logic        exp_ready;
    int          exp_idx;
    logic        exp_df;
  } vec_t;

  vec_t vecs[12];

  // Reference model state: plain bitmap plus sticky error flag.
  logic [N-1:0] m_busy;
  logic         m_df;

  function automatic int zeros(input logic [N-1:0] map);
    int n = 0;
    for (int i = 0; i < N; i++) if (!map[i]) n++;
    return n;
  endfunction

  function automatic int lowest_free(input logic [N-1:0] map);
    for (int i = 0; i < N; i++) if (!map[i]) return i;
    return 0;
  endfunction

  function automatic phys_idx_t pick_idx(input logic [N-1:0] map);
    int start = $urandom_range(0, N - 1);
    if ($urandom_range(0, 9) == 0) return phys_idx_t'(start);
    for (int k = 0; k < N; k++) begin
      int j = (start + k) % N;
      if (map[j]) return phys_idx_t'(j);
    end
    return phys_idx_t'(start);
  endfunction

  task automatic model_edge();
    logic [N-1:0] old_map;
    int freed[$];
    phys_idx_t idx[2];
    if (rst) begin
      m_busy = RESET_MAP;
      m_df   = 1'b0;
    end else if (recover_valid) begin
      m_busy = recover_busy;
    end else begin
      old_map = m_busy;
      idx[0] = rel_index0;
      idx[1] = rel_index1;
      if (alloc_req && zeros(old_map) > 0) m_busy[lowest_free(old_map)] = 1'b1;
      for (int p = 0; p < 2; p++) begin
        if (rel_valid[p]) begin
          int k = int'(idx[p]);
          if (old_map[k] && !(k inside {freed})) begin
            m_busy[k] = 1'b0;
            freed.push_back(k);
          end else begin
            m_df = 1'b1;
          end
        end
      end
    end
  endtask

  initial begin
    // rst, alloc, rel_valid, r0, r1, rec, rec_busy, exp_busy, exp_free, exp_ready, exp_idx, exp_df
    vecs[0]  = '{1'b1, 1'b0, 2'b00, 0,  0, 1'b0, 64'h0, 64'h00000000_FFFFFFFF, 32, 1'b1, 32, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 2'b01, 3,  0, 1'b0, 64'h0, 64'h00000001_FFFFFFF7, 32, 1'b1, 3,  1'b0};
    vecs[2]  = '{1'b0, 1'b0, 2'b11, 7,  7, 1'b0, 64'h0, 64'h00000001_FFFFFF77, 33, 1'b1, 3,  1'b1};
    vecs[3]  = '{1'b0, 1'b0, 2'b00, 0,  0, 1'b0, 64'h0, 64'h00000001_FFFFFF77, 33, 1'b1, 3,  1'b1};
    vecs[4]  = '{1'b1, 1'b1, 2'b01, 9,  0, 1'b1, 64'h0, 64'h00000000_FFFFFFFF, 32, 1'b1, 32, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 2'b01, 50, 0, 1'b0, 64'h0, 64'h00000000_FFFFFFFF, 32, 1'b1, 32, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 2'b01, 10, 0, 1'b1, 64'h0000FFFF_FFFFFFFF,
                 64'h0000FFFF_FFFFFFFF, 16, 1'b1, 48, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 2'b00, 0,  0, 1'b0, 64'h0, 64'h00000000_FFFFFFFF, 32, 1'b1, 32, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 2'b10, 0,  0, 1'b0, 64'h0, 64'h00000001_FFFFFFFE, 32, 1'b1, 0,  1'b0};
    vecs[9]  = '{1'b0, 1'b0, 2'b00, 0,  0, 1'b1, 64'hFFFFFFFF_FFFFFFFF,
                 64'hFFFFFFFF_FFFFFFFF, 0, 1'b0, 0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 2'b00, 0,  0, 1'b1, 64'h0, 64'h0, 64, 1'b1, 0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 2'b00, 0,  0, 1'b0, 64'h0, 64'h1, 63, 1'b1, 1, 1'b0};

    step();
    step();
    idle_inputs();

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      rst = vecs[i].rst; alloc_req = vecs[i].alloc; rel_valid = vecs[i].rv;
      rel_index0 = phys_idx_t'(vecs[i].r0); rel_index1 = phys_idx_t'(vecs[i].r1);
      recover_valid = vecs[i].rec; recover_busy = vecs[i].rec_busy;
      step();
      idle_inputs();
      check($sformatf("vec%0d_busy", i),  busy_table,          vecs[i].exp_busy);
      check($sformatf("vec%0d_free", i),  64'(free_count),     64'(vecs[i].exp_free));
      check($sformatf("vec%0d_ready", i), 64'(alloc_ready),    64'(vecs[i].exp_ready));
      check($sformatf("vec%0d_idx", i),   64'(alloc_index),    64'(vecs[i].exp_idx));
      check($sformatf("vec%0d_df", i),    64'(double_free),    64'(vecs[i].exp_df));
    end

    // Fill from reset: indices 32..63 in order, then full.
    rst = 1'b1; step(); idle_inputs();
    for (int i = 0; i < 32; i++) begin
      check("fill_idx", 64'(alloc_index), 64'(32 + i));
      check("fill_ready", 64'(alloc_ready), 64'(1));
      alloc_req = 1'b1;
      step();
    end
    alloc_req = 1'b0;
    check("full_ready", 64'(alloc_ready), 64'(0));
    check("full_idx",   64'(alloc_index), 64'(0));
    check("full_free",  64'(free_count),  64'(0));
    alloc_req = 1'b1; step(); alloc_req = 1'b0;
    check("full_extra_busy", busy_table, {N{1'b1}});
    check("full_extra_free", 64'(free_count), 64'(0));
    check("full_extra_df",   64'(double_free), 64'(0));

    // Two releases from full, then drain them back in index order.
    rel_valid = 2'b11; rel_index0 = 6'd5; rel_index1 = 6'd40;
    step(); idle_inputs();
    check("rel2_free", 64'(free_count), 64'(2));
    check("rel2_idx",  64'(alloc_index), 64'(5));
    alloc_req = 1'b1; step();
    check("realloc_idx40", 64'(alloc_index), 64'(40));
    step(); alloc_req = 1'b0;
    check("realloc_full_ready", 64'(alloc_ready), 64'(0));
    check("realloc_full_busy",  busy_table, {N{1'b1}});

    // Randomized traffic against the reference model.
    rst = 1'b1;
    model_edge();
    step();
    idle_inputs();
    for (int c = 0; c < 900; c++) begin
      int r = $urandom_range(0, 199);
      int bias = (c / 150) % 3 == 0 ? 85 : ((c / 150) % 3 == 1 ? 50 : 15);
      rst           = (r == 0);
      recover_valid = (r >= 1 && r <= 4);
      case ($urandom_range(0, 3))
        0:       recover_busy = '0;
        1:       recover_busy = {N{1'b1}};
        default: recover_busy = {$urandom, $urandom};
      endcase
      alloc_req  = ($urandom_range(0, 99) < bias);
      rel_valid  = ($urandom_range(0, 99) < 100 - bias) ? 2'($urandom_range(0, 3)) : 2'b00;
      rel_index0 = pick_idx(m_busy);
      rel_index1 = ($urandom_range(0, 19) == 0) ? rel_index0 : pick_idx(m_busy);
      model_edge();
      step();
      idle_inputs();
      check("rnd_busy",  busy_table,          m_busy);
      check("rnd_free",  64'(free_count),     64'(zeros(m_busy)));
      check("rnd_ready", 64'(alloc_ready),    64'(zeros(m_busy) > 0));
      check("rnd_idx",   64'(alloc_index),    64'(lowest_free(m_busy)));
      check("rnd_df",    64'(double_free),    64'(m_df));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/phys_reg_free_table.md
Name: phys_reg_free_table

Overview:
- Owns the physical-register busy bitmap for the rename stage.
- Hands out the lowest-numbered free physical register to rename via a ready/request handshake.
- Takes freed registers back from retire on two release ports, each addressed by index.
- Supports whole-table recovery on a pipeline flush, and keeps a running free count for stall logic.

Parameters:
ENTRY_COUNT, 64, number of physical registers (power of two, >= 4)
RESERVED, 32, entries 0..RESERVED-1 marked busy at reset (initial architectural mappings)
IDX_W, $clog2(ENTRY_COUNT), index width (derived, not overridden)
CNT_W, $clog2(ENTRY_COUNT+1), free-count width (derived)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
alloc_req  input  1  rename consumes alloc_index this cycle
alloc_ready  output  1  at least one free entry exists
alloc_index  output  IDX_W  lowest free entry; 0 when alloc_ready=0
rel_valid  input  2  per-port release strobe (bit 0 = port 0)
rel_index0  input  IDX_W  entry freed by port 0
rel_index1  input  IDX_W  entry freed by port 1
recover_valid  input  1  load busy table from recover_busy
recover_busy  input  ENTRY_COUNT  checkpointed busy map, 1 = busy
busy_table  output  ENTRY_COUNT  current registered busy map, 1 = busy
free_count  output  CNT_W  number of zero bits in busy_table
double_free  output  1  sticky error flag; cleared only by rst

Behaviour:
- State: registered busy_table, free_count, double_free.
- Reset (rst=1 at edge):
  - busy_table bits [RESERVED-1:0]=1, all others 0.
  - free_count=ENTRY_COUNT-RESERVED; double_free=0.
  - rst overrides every other input.
- alloc_ready/alloc_index are combinational from the registered busy_table only. No bypass of same-cycle releases.
- alloc_index = lowest i with busy_table[i]==0.
- alloc fire = alloc_req & alloc_ready. On fire, bit alloc_index is set at the next edge.
- alloc_req while alloc_ready=0: ignored, no state change, no error.
- Release port p fires when rel_valid[p]=1 and busy_table[rel_indexp]==1. It clears that bit at the next edge.
- Release of an entry already 0: no change to table or count; double_free set.
- Both ports name the same busy entry: cleared once, counted once, double_free set.
- Alloc index equal to a release index in the same cycle: impossible for a legal release, because an allocated entry is free (0) in the table. That release is therefore a double free, handled as above; the alloc still completes (bit set).
- Entries < RESERVED are freely releasable; after reset they are ordinary entries.
- free_count next = free_count - alloc_fire + number of effective (non-duplicate, busy) releases. It never wraps.
- Invariant: free_count == popcount(~busy_table) every cycle.
- recover_valid=1 (and rst=0):
  - busy_table <= recover_busy; free_count <= popcount(~recover_busy).
  - Same-cycle alloc and releases are discarded; double_free is not updated.
  - alloc_ready in that cycle still reflects the old table; rename must treat the flush as killing its request.
- Priority at an edge: rst > recover_valid > alloc/release update.
- Full (free_count==0): alloc_ready=0, alloc_index=0.
- Empty (all free): alloc_index=0.
- Latency: allocation/release visible on busy_table, free_count and alloc_index one cycle after the fire edge.

Decomposition:
- Shared rename package holds:
  - ENTRY_COUNT/RESERVED defaults
  - the phys_idx_t typedef (IDX_W bits)
  - the free-count typedef.
- Lowest-free search reuses the existing priority_encoder (free_table <= busy_table; 0 = free convention matches).
- Release index-to-one-hot decode and popcount stay inline; no further sub-modules.

Test Plan:
- Reset with ENTRY_COUNT=64, RESERVED=32 -> busy_table=0x00000000_FFFFFFFF, free_count=32, alloc_ready=1, alloc_index=32, double_free=0.
- alloc_req held 32 cycles -> indices 32,33..63 issued in order; then alloc_ready=0, alloc_index=0, free_count=0; a 33rd alloc_req changes nothing.
- From full: rel_valid=2'b11, rel_index0=5, rel_index1=40 -> next cycle free_count=2, alloc_index=5; alloc then returns 5, then 40.
- Same cycle alloc_req=1 (index 32) and rel_valid=2'b01, rel_index0=3 -> next cycle bit 32 set, bit 3 clear, free_count unchanged at 32, alloc_index=3.
- rel_valid=2'b11, both indices=7 on busy entry -> bit 7 cleared once, free_count+1, double_free=1 and stays 1 until rst; releasing free entry 50 alone also sets double_free.
- Recovery mid-stream: recover_valid=1, recover_busy=0x0000FFFF_FFFFFFFF, with alloc_req and a release also asserted -> next cycle busy_table equals recover_busy exactly, free_count=16, alloc_index=48; then rst=1 -> reset values restored.
